feeder_scheduler: RTL and testbench
===================================

Name: feeder_scheduler

Overview:
- Sequences the distance-module array for the outlier-removal filter.
- For each query point it issues cache chunk reads (DISTANCE_MODULES points per chunk) towards the feeder/distance pipeline, then collects per-lane in-radius hit vectors and counts valid neighbours.
- It emits one keep/remove decision per point, stopping the chunk scan early once the neighbour threshold is reached.

Parameters:
- DISTANCE_MODULES, 32, lanes per chunk; width of hit vector.
- ADDR_W, 12, point index width (max 4095 points per frame).
- CNT_W, 8, neighbour counter / threshold width.
- MAX_OUT, 4, maximum chunks in flight in the feeder/distance pipeline.

Ports:
- clock  in  1  system clock, all logic posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; latches num_points/min_neighbors and begins a frame when idle.
- num_points  in  ADDR_W  points in frame.
- min_neighbors  in  CNT_W  keep threshold (keep iff count >= threshold).
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last decision is accepted.
- point_idx  out  ADDR_W  current query point (drives query-point select).
- chunk_valid  out  1  one-cycle pulse per chunk read issued.
- chunk_addr  out  ADDR_W  chunk number k; covers points k*DISTANCE_MODULES onward.
- hit_valid  in  1  hit vector valid; returned in issue order.
- hit_vec  in  DISTANCE_MODULES  lane l set = point k*DM+l within radius.
- result_valid  out  1  decision available.
- result_ready  in  1  consumer accepts decision.
- result_idx  out  ADDR_W  point index of decision.
- result_keep  out  1  1 = keep, 0 = remove.
- overflow_err  out  1  sticky; hit_valid received with zero outstanding chunks.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters cleared. Reset mid-frame abandons the frame with no done pulse. Hits arriving in the cycle after reset are ignored and do not set overflow_err.
- Chunk count: NCH = ceil(num_points/DISTANCE_MODULES), computed at start.
- IDLE:
  - start=1 with num_points=0 goes straight to FINISH.
  - Otherwise latch inputs, point_idx=0, busy=1, go to SCAN.
  - start is ignored outside IDLE.
- SCAN:
  - Each cycle, issue chunk k (chunk_valid=1, chunk_addr=k) while k<NCH, outstanding<MAX_OUT, and no early stop.
  - An issue and a return in the same cycle leave outstanding unchanged.
  - If min_neighbors=0, issue nothing: the decision is keep and the FSM goes directly to EMIT.
- Hit accounting, per hit_valid, for the oldest outstanding chunk kr:
  - Mask lanes with kr*DM+l >= num_points.
  - Mask the self lane kr*DM+l == point_idx.
  - count += popcount(masked), saturating at 2^CNT_W-1.
- Early stop: when count >= min_neighbors, stop issuing. Drain remaining outstanding hits without counting them, then go to EMIT.
- Scan end: all NCH chunks returned, outstanding=0 → EMIT.
- EMIT:
  - result_valid=1, result_idx=point_idx, result_keep=(count>=min_neighbors).
  - result_idx and result_keep are held stable while result_valid && !result_ready.
  - On accept: clear count, k, and outstanding tracking. If point_idx==num_points-1 go to FINISH; otherwise point_idx+1 and back to SCAN on the next cycle.
- FINISH: done=1 for one cycle, busy=0, then IDLE.
- Latency:
  - First chunk_valid appears 1 cycle after start.
  - result_valid appears 1 cycle after the final needed hit_valid.
  - Back-to-back issue at 1 chunk/cycle when MAX_OUT permits.
- hit_valid with outstanding=0 sets overflow_err (cleared only by reset) and is otherwise ignored.

Test Plan:
- num_points=40, min_neighbors=3, hits all-ones, immediate return → point 0: chunk 0 returns count=31 (self masked); early stop; exactly one chunk issued per point if returns are 1-cycle; 40 results all keep=1; done pulses once.
- num_points=40, min_neighbors=10, chunk0 hit_vec=0x00000001 (self only), chunk1 hit_vec=0xFFFFFFFF → for point 0 count=8 (lanes 8..31 masked); keep=0, result_idx=0.
- num_points=0, start → done pulses 2 cycles after start; chunk_valid and result_valid never assert.
- min_neighbors=0, num_points=5 → five results keep=1, zero chunk_valid pulses.
- Hit latency 10 cycles, MAX_OUT=4, num_points=320 → at most 4 chunk_valid pulses before the first hit_valid; chunk_addr runs 0..9 in order.
- result_ready held low 5 cycles → result_idx/result_keep stable and no further chunk_valid issued; hit_valid pulse while idle sets overflow_err; reset asserted mid-SCAN → all outputs 0 next cycle.

Source files
------------

// File: rtl/feeder_scheduler.sv
`default_nettype none
// feeder_scheduler -- issues chunk reads per query point, counts in-radius hits and
// emits one keep/remove decision per point with early stop.  Revision 1.0
module feeder_scheduler #(
  parameter int DISTANCE_MODULES = 32,
  parameter int ADDR_W           = 12,
  parameter int CNT_W            = 8,
  parameter int MAX_OUT          = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           num_points,
  input  logic [CNT_W-1:0]            min_neighbors,
  output logic                        busy,
  output logic                        done,
  output logic [ADDR_W-1:0]           point_idx,
  output logic                        chunk_valid,
  output logic [ADDR_W-1:0]           chunk_addr,
  input  logic                        hit_valid,
  input  logic [DISTANCE_MODULES-1:0] hit_vec,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic [ADDR_W-1:0]           result_idx,
  output logic                        result_keep,
  output logic                        overflow_err
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int PW = $clog2(DISTANCE_MODULES + 1);
  localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam int IW = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    EMIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] np;
  logic [CNT_W-1:0]  mn;
  logic [IW-1:0]     nch;
  logic [IW-1:0]     k;
  logic [IW-1:0]     kr;
  logic [OW-1:0]     outstanding;
  logic [CNT_W-1:0]  count;
  logic              rst_d;

  logic [IW-1:0]     start_nch;
  logic [IW-1:0]     base;
  logic [IW-1:0]     lane;
  logic [PW-1:0]     pop;
  logic [SW-1:0]     sum;
  logic              hit_ok;
  logic              hit_take;
  logic [CNT_W-1:0]  count_nx;
  logic              stop_nx;
  logic [OW-1:0]     out_ret;
  logic [OW-1:0]     out_nx;
  logic              issue;

  assign start_nch = (IW'(num_points) + IW'(DISTANCE_MODULES - 1)) / IW'(DISTANCE_MODULES);

  // outstanding counts the chunk being presented this cycle, so a zero-latency
  // return in the same cycle is accounted against it.
  always_comb begin
    base = kr * IW'(DISTANCE_MODULES);
    pop  = '0;
    lane = '0;
    for (int l = 0; l < DISTANCE_MODULES; l++) begin
      lane = base + IW'(l);
      if (hit_vec[l] && (lane < IW'(np)) && (lane != IW'(point_idx)))
        pop = pop + PW'(1);
    end
    hit_ok   = hit_valid && !rst_d;
    hit_take = hit_ok && (outstanding != '0);
    sum      = SW'(count) + SW'(pop);
    count_nx = count;
    if (hit_take && (count < mn))
      count_nx = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    stop_nx  = (count_nx >= mn);
    out_ret  = outstanding - OW'(hit_take);
    issue    = (state == SCAN) && (k < nch) && (out_ret < OW'(MAX_OUT)) && !stop_nx;
    out_nx   = out_ret + OW'(issue);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      np           <= '0;
      mn           <= '0;
      nch          <= '0;
      k            <= '0;
      kr           <= '0;
      outstanding  <= '0;
      count        <= '0;
      rst_d        <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      point_idx    <= '0;
      chunk_valid  <= 1'b0;
      chunk_addr   <= '0;
      result_valid <= 1'b0;
      result_idx   <= '0;
      result_keep  <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      rst_d       <= 1'b0;
      chunk_valid <= 1'b0;
      done        <= 1'b0;
      if (hit_ok && (outstanding == '0))
        overflow_err <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            np          <= num_points;
            mn          <= min_neighbors;
            nch         <= start_nch;
            point_idx   <= '0;
            k           <= '0;
            kr          <= '0;
            outstanding <= '0;
            count       <= '0;
            if (num_points == '0) begin
              state <= FINISH;
            end else begin
              state <= SCAN;
              if (min_neighbors != '0) begin
                chunk_valid <= 1'b1;
                chunk_addr  <= '0;
                k           <= IW'(1);
                outstanding <= OW'(1);
              end
            end
          end
        end
        SCAN: begin
          count       <= count_nx;
          outstanding <= out_nx;
          if (hit_take)
            kr <= kr + IW'(1);
          if (issue) begin
            chunk_valid <= 1'b1;
            chunk_addr  <= ADDR_W'(k);
            k           <= k + IW'(1);
          end
          if ((out_nx == '0) && (stop_nx || (k == nch))) begin
            state        <= EMIT;
            result_valid <= 1'b1;
            result_idx   <= point_idx;
            result_keep  <= stop_nx;
          end
        end
        EMIT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            count        <= '0;
            k            <= '0;
            kr           <= '0;
            outstanding  <= '0;
            if (point_idx == (np - ADDR_W'(1))) begin
              state <= FINISH;
            end else begin
              point_idx <= point_idx + ADDR_W'(1);
              state     <= SCAN;
              if (mn != '0) begin
                chunk_valid <= 1'b1;
                chunk_addr  <= '0;
                k           <= IW'(1);
                outstanding <= OW'(1);
              end
            end
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_feeder_scheduler.sv
`default_nettype none
// tb_feeder_scheduler -- randomized frames against a neighbour-count reference model,
// with an in-order hit responder and a scoreboard monitor on the decision stream.
module tb_feeder_scheduler;

  localparam int DM      = 32;
  localparam int ADDR_W  = 12;
  localparam int CNT_W   = 8;
  localparam int MAX_OUT = 4;

  logic              clock;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] num_points;
  logic [CNT_W-1:0]  min_neighbors;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] point_idx;
  logic              chunk_valid;
  logic [ADDR_W-1:0] chunk_addr;
  logic              hit_valid = 1'b0;
  logic [DM-1:0]     hit_vec = '0;
  logic              result_valid;
  logic              result_ready = 1'b0;
  logic [ADDR_W-1:0] result_idx;
  logic              result_keep;
  logic              overflow_err;

  feeder_scheduler #(
    .DISTANCE_MODULES(DM), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .num_points(num_points),
    .min_neighbors(min_neighbors), .busy(busy), .done(done), .point_idx(point_idx),
    .chunk_valid(chunk_valid), .chunk_addr(chunk_addr), .hit_valid(hit_valid),
    .hit_vec(hit_vec), .result_valid(result_valid), .result_ready(result_ready),
    .result_idx(result_idx), .result_keep(result_keep), .overflow_err(overflow_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct { int idx; bit keep; int chunks; } exp_t;
  typedef struct { int pt; int addr; int due; } pend_t;

  exp_t  exp_q[$];
  pend_t pend_q[$];
  int checks = 0, errors = 0, cyc = 0;
  int lat = 0, hmode = 0, dens = 0, cur_np = 0, cur_mn = 0;
  int unsigned seed = 0;
  bit inject = 0, ready_rand = 0, force_low = 0;
  int chunk_total = 0, result_total = 0, done_total = 0, pt_chunks = 0;
  bit hold_v = 0;
  int hold_idx = 0;
  bit hold_keep = 0;
  exp_t  mon_e;
  pend_t rsp_e;
  logic [DM-1:0] rsp_vec;

  always @(posedge clock) cyc++;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // neighbour relation: mode 1 everyone is a neighbour, mode 2 only point 0 and points 32..63
  function automatic bit hitbit(int unsigned p, int unsigned j);
    int unsigned h;
    if (hmode == 1) return 1'b1;
    if (hmode == 2) return (j == 0) || (j >= DM && j < 2 * DM);
    h = seed ^ (p * 32'h9E3779B1) ^ (j * 32'h85EBCA77);
    h = h ^ (h >> 15);
    h = h * 32'h2C1B3C6D;
    h = h ^ (h >> 12);
    return (h % 100) < dens;
  endfunction

  function automatic exp_t model(int p);
    exp_t e;
    int cnt = 0;
    int need = -1;
    int nch = (cur_np + DM - 1) / DM;
    for (int c = 0; c < nch; c++) begin
      for (int l = 0; l < DM; l++) begin
        int j = c * DM + l;
        if (j < cur_np && j != p && hitbit(p, j)) cnt++;
      end
      if (need < 0 && cnt >= cur_mn) need = c + 1;
    end
    if (cnt > 255) cnt = 255;
    e.idx  = p;
    e.keep = (cnt >= cur_mn);
    if (cur_mn == 0)  e.chunks = 0;
    else if (!e.keep) e.chunks = nch;
    else if (lat == 0) e.chunks = need;
    else              e.chunks = -1;
    return e;
  endfunction

  // in-order responder: each issued chunk returns its hit vector lat cycles later
  always @(negedge clock) begin
    if (reset) begin
      pend_q.delete();
      hit_valid = 1'b0;
      hit_vec   = '0;
    end else begin
      if (chunk_valid) begin
        pend_q.push_back('{pt: int'(point_idx), addr: int'(chunk_addr), due: cyc + lat});
        chk("outstanding_limit", (pend_q.size() <= MAX_OUT) ? 1 : 0, 1);
      end
      rsp_vec = '0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        rsp_e = pend_q.pop_front();
        for (int l = 0; l < DM; l++) rsp_vec[l] = hitbit(rsp_e.pt, rsp_e.addr * DM + l);
        hit_valid = 1'b1;
      end else begin
        hit_valid = inject;
      end
      hit_vec = rsp_vec;
    end
  end

  always @(posedge clock) begin
    #1;
    if (force_low)       result_ready = 1'b0;
    else if (ready_rand) result_ready = ($urandom_range(0, 3) != 0);
    else                 result_ready = 1'b1;
  end

  // scoreboard monitor
  always @(negedge clock) begin
    if (reset) begin
      pt_chunks = 0;
      hold_v    = 0;
    end else begin
      if (done) done_total++;
      if (chunk_valid) begin
        chunk_total++;
        chk("chunk_point", int'(point_idx), (exp_q.size() > 0) ? exp_q[0].idx : -1);
        chk("chunk_addr_order", int'(chunk_addr), pt_chunks);
        chk("chunk_during_result", int'(result_valid), 0);
        pt_chunks++;
      end
      if (result_valid) begin
        if (hold_v) begin
          chk("result_idx_hold", int'(result_idx), hold_idx);
          chk("result_keep_hold", int'(result_keep), int'(hold_keep));
        end
        if (result_ready) begin
          hold_v = 0;
          result_total++;
          if (exp_q.size() == 0) begin
            chk("result_unexpected", int'(result_idx), -1);
          end else begin
            mon_e = exp_q.pop_front();
            chk("result_idx", int'(result_idx), mon_e.idx);
            chk("result_keep", int'(result_keep), int'(mon_e.keep));
            if (mon_e.chunks >= 0) chk("chunks_per_point", pt_chunks, mon_e.chunks);
          end
          pt_chunks = 0;
        end else begin
          hold_v    = 1;
          hold_idx  = int'(result_idx);
          hold_keep = result_keep;
        end
      end
    end
  end

  task automatic check_zero(string name);
    chk(name, int'({busy, done, point_idx, chunk_valid, chunk_addr, result_valid,
                    result_idx, result_keep, overflow_err}), 0);
  endtask

  task automatic start_frame(int np, int mn, int l, int mode, int d);
    cur_np = np; cur_mn = mn; lat = l; hmode = mode; dens = d; seed = $urandom;
    for (int p = 0; p < np; p++) exp_q.push_back(model(p));
    @(posedge clock); #1;
    num_points = ADDR_W'(np); min_neighbors = CNT_W'(mn); start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    chk("first_chunk_latency", int'(chunk_valid), (np > 0 && mn > 0) ? 1 : 0);
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_done(int budget, string name);
    int n = 0;
    int d0 = done_total;
    while (done_total == d0 && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    chk({name, "_done_in_budget"}, (n < budget) ? 1 : 0, 1);
    repeat (3) @(posedge clock);
    #1;
    chk({name, "_done_once"}, done_total - d0, 1);
    chk({name, "_results_drained"}, exp_q.size(), 0);
    chk({name, "_busy_low"}, int'(busy), 0);
    chk({name, "_no_overflow"}, int'(overflow_err), 0);
    if (n >= budget) begin
      exp_q.delete();
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
    end
  endtask

  initial begin
    int c0, r0, d0, hidx;
    bit hkeep;
    reset = 1'b1; start = 1'b0; num_points = '0; min_neighbors = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero("reset_state");
    @(posedge clock); #1 reset = 1'b0;

    // all-ones hits, zero-latency return: one chunk per point, all kept
    c0 = chunk_total; r0 = result_total;
    start_frame(40, 3, 0, 1, 0);
    wait_done(2000, "allones");
    chk("allones_chunks", chunk_total - c0, 40);
    chk("allones_results", result_total - r0, 40);

    // self lane and out-of-frame lanes masked: point 0 counts only 8
    start_frame(40, 10, 1, 2, 0);
    wait_done(4000, "masking");

    // empty frame
    c0 = chunk_total; r0 = result_total;
    start_frame(0, 5, 1, 0, 40);
    chk("empty_done_early", int'(done), 0);
    @(posedge clock); #1;
    chk("empty_done_pulse", int'(done), 1);
    chk("empty_busy_low", int'(busy), 0);
    @(posedge clock); #1;
    chk("empty_done_single", int'(done), 0);
    chk("empty_no_chunks", chunk_total - c0, 0);
    chk("empty_no_results", result_total - r0, 0);

    // zero threshold: keep everything without reading
    c0 = chunk_total; r0 = result_total;
    start_frame(5, 0, 1, 0, 40);
    wait_done(500, "zero_thresh");
    chk("zero_thresh_chunks", chunk_total - c0, 0);
    chk("zero_thresh_results", result_total - r0, 5);

    // long latency, full scans of 10 chunks
    start_frame(320, 255, 10, 0, 40);
    wait_done(30000, "long_latency");

    // randomized frames with random backpressure
    ready_rand = 1;
    for (int f = 0; f < 16; f++) begin
      start_frame($urandom_range(1, 70), $urandom_range(0, 45), $urandom_range(0, 8),
                  0, $urandom_range(20, 60));
      wait_done(6000, "random");
    end
    ready_rand = 0;

    // held backpressure: decision stable, no issue while waiting
    force_low = 1;
    repeat (2) @(posedge clock);
    start_frame(3, 2, 2, 0, 50);
    for (int n = 0; n < 200 && !result_valid; n++) @(negedge clock);
    chk("bp_result_seen", int'(result_valid), 1);
    hidx = int'(result_idx); hkeep = result_keep; c0 = chunk_total;
    repeat (5) @(negedge clock);
    chk("bp_valid_held", int'(result_valid), 1);
    chk("bp_idx_stable", int'(result_idx), hidx);
    chk("bp_keep_stable", int'(result_keep), int'(hkeep));
    chk("bp_no_issue", chunk_total - c0, 0);
    force_low = 0;
    wait_done(1000, "backpressure");

    // reset in the middle of a scan
    d0 = done_total;
    start_frame(100, 60, 5, 0, 30);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    exp_q.delete();
    @(posedge clock);
    @(negedge clock);
    check_zero("reset_mid_scan");
    @(posedge clock); #1 reset = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("reset_no_done", done_total - d0, 0);
    chk("reset_idle_busy", int'(busy), 0);

    // stray hits: ignored right after reset, flagged when idle
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0; inject = 1'b1;
    @(posedge clock); #1 inject = 1'b0;
    @(negedge clock);
    chk("post_reset_hit_ignored", int'(overflow_err), 0);
    repeat (2) @(posedge clock);
    #1 inject = 1'b1;
    @(posedge clock); #1 inject = 1'b0;
    @(negedge clock);
    chk("idle_hit_overflow", int'(overflow_err), 1);
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("overflow_sticky", int'(overflow_err), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
